// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the pipelined ALU: default datapath
//               width, CTRL opcode constants and the control state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_width_default = 32;

    // CTRL opcodes; 12..15 are reserved and produce R=0
    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_xor  = 4'd4;
    localparam logic [3:0] c_op_nor  = 4'd5;
    localparam logic [3:0] c_op_slt  = 4'd6;
    localparam logic [3:0] c_op_sltu = 4'd7;
    localparam logic [3:0] c_op_sll  = 4'd8;
    localparam logic [3:0] c_op_srl  = 4'd9;
    localparam logic [3:0] c_op_sra  = 4'd10;
    localparam logic [3:0] c_op_mul  = 4'd11;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative unsigned shift-add multiplier, one partial product
//               per clock, WIDTH clocks per multiply.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_start         - load operands and begin (ignored mid-run)
//               i_a, i_b        - multiplicand, multiplier
//               o_done          - high during the last step's cycle
//               o_prod_hi/lo    - full product, valid while o_done is high
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod_hi,
    output logic [WIDTH-1:0] o_prod_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    // Upper half accumulates partial sums; lower half holds the multiplier
    // bits not yet consumed, shifting right one bit per step.
    logic [2*WIDTH-1:0] r_prod;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_last;

    always_comb begin
        w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                    + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_prod_next = {w_sum, r_prod[WIDTH-1:1]};
        w_last      = (r_cnt == CNT_W'(WIDTH-1));
    end

    // The final product is presented combinationally so the caller can
    // register it on the same edge that performs the last step.
    assign o_done    = r_busy && w_last;
    assign o_prod_hi = w_prod_next[2*WIDTH-1:WIDTH];
    assign o_prod_lo = w_prod_next[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_mcand <= i_a;
            r_prod  <= {{WIDTH{1'b0}}, i_b};
        end else if (r_busy) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Registered ALU. Single-cycle ops produce a result one clock
//               after acceptance; MUL runs on an iterative multiplier and
//               holds off new work (ready low) for WIDTH clocks.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               A, B, CTRL      - operands and opcode
//               valid_in        - operation presented (taken when ready)
//               ready           - block can accept an operation
//               R, zero, ovf    - registered result and flags
//               valid_out       - one-cycle pulse when R/zero/ovf update
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       CTRL,
    input  logic             valid_in,
    output logic             ready,
    output logic [WIDTH-1:0] R,
    output logic             zero,
    output logic             ovf,
    output logic             valid_out
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_valid;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SH_W-1:0]  w_shamt;
    logic [WIDTH-1:0] w_alu_r;
    logic             w_alu_ovf;

    logic             w_mul_start;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

    logic             w_load;
    logic [WIDTH-1:0] w_load_r;
    logic             w_load_ovf;

    // ------------------------------------------------------------------
    // Single-cycle datapath. MUL and reserved opcodes fall to the
    // default (R=0, ovf=0); MUL's real result comes from the multiplier.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum     = A + B;
        w_diff    = A - B;
        w_shamt   = B[SH_W-1:0];
        w_alu_r   = '0;
        w_alu_ovf = 1'b0;
        case (CTRL)
            c_op_add: begin
                w_alu_r   = w_sum;
                // Same-sign operands yielding an opposite-sign sum
                w_alu_ovf = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
            end
            c_op_sub: begin
                w_alu_r   = w_diff;
                // Opposite-sign operands where the result sign flips from A
                w_alu_ovf = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
            end
            c_op_and:  w_alu_r = A & B;
            c_op_or:   w_alu_r = A | B;
            c_op_xor:  w_alu_r = A ^ B;
            c_op_nor:  w_alu_r = ~(A | B);
            c_op_slt:  w_alu_r = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            c_op_sltu: w_alu_r = {{(WIDTH-1){1'b0}}, (A < B)};
            c_op_sll:  w_alu_r = A << w_shamt;
            c_op_srl:  w_alu_r = A >> w_shamt;
            c_op_sra:  w_alu_r = $signed(A) >>> w_shamt;
            default: begin
                w_alu_r   = '0;
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (reset),
        .i_start   (w_mul_start),
        .i_a       (A),
        .i_b       (B),
        .o_done    (w_mul_done),
        .o_prod_hi (w_mul_hi),
        .o_prod_lo (w_mul_lo)
    );

    // ------------------------------------------------------------------
    // Control: next state and result-load selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        w_load       = 1'b0;
        w_load_r     = w_alu_r;
        w_load_ovf   = w_alu_ovf;
        case (r_state)
            ST_IDLE: begin
                if (valid_in) begin
                    if (CTRL == c_op_mul) begin
                        w_mul_start  = 1'b1;
                        w_state_next = ST_MUL_BUSY;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (w_mul_done) begin
                    w_load       = 1'b1;
                    w_load_r     = w_mul_lo;
                    w_load_ovf   = |w_mul_hi;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_load;
            if (w_load) begin
                r_result <= w_load_r;
                // Flag derived from the value being loaded, not the old R
                r_zero   <= (w_load_r == '0);
                r_ovf    <= w_load_ovf;
            end
        end
    end

    assign ready     = (r_state == ST_IDLE);
    assign R         = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe. Drives a 32-bit and an
//               8-bit instance with the same stimulus and compares both
//               against an arithmetic reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    typedef longint unsigned u64_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        valid_in;

    logic        rdy32, z32, o32, v32;
    logic [31:0] r32;
    logic        rdy8, z8, o8, v8;
    logic [7:0]  r8;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .A(a), .B(b), .CTRL(ctrl), .valid_in(valid_in),
        .ready(rdy32), .R(r32), .zero(z32), .ovf(o32), .valid_out(v32)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .A(a[7:0]), .B(b[7:0]), .CTRL(ctrl), .valid_in(valid_in),
        .ready(rdy8), .R(r8), .zero(z8), .ovf(o8), .valid_out(v8)
    );

    // ---------------- reference model (index 0: WIDTH=32, 1: WIDTH=8) ----
    int   c_w [2] = '{32, 8};
    u64_t m_r [2];
    bit   m_zero [2];
    bit   m_ovf [2];
    bit   m_vout [2];
    int   m_busy [2];
    u64_t m_pend [2];
    bit   m_pend_ovf [2];

    function automatic longint sext(input u64_t v, input int w);
        if (((v >> (w - 1)) & 64'd1) != 0) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    function automatic void ref_op(input int w, input logic [3:0] op,
                                   input u64_t a_in, input u64_t b_in,
                                   output u64_t r, output bit ov);
        u64_t   mask = (64'd1 << w) - 64'd1;
        u64_t   ua   = a_in & mask;
        u64_t   ub   = b_in & mask;
        longint sa   = sext(ua, w);
        longint sb   = sext(ub, w);
        longint smax = (longint'(1) << (w - 1)) - 1;
        longint smin = -(longint'(1) << (w - 1));
        int     sh   = int'(ub % u64_t'(w));
        longint t;
        u64_t   p;
        r  = 0;
        ov = 0;
        case (op)
            4'd0: begin t = sa + sb; r = u64_t'(t) & mask; ov = (t > smax) || (t < smin); end
            4'd1: begin t = sa - sb; r = u64_t'(t) & mask; ov = (t > smax) || (t < smin); end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: r = ~(ua | ub) & mask;
            4'd6: r = (sa < sb) ? 64'd1 : 64'd0;
            4'd7: r = (ua < ub) ? 64'd1 : 64'd0;
            4'd8: r = (ua << sh) & mask;
            4'd9: r = ua >> sh;
            4'd10: r = u64_t'(sa >>> sh) & mask;
            4'd11: begin p = ua * ub; r = p & mask; ov = (p >> w) != 0; end
            default: r = 0;
        endcase
    endfunction

    // Advance the model across one rising edge with the inputs just sampled.
    task automatic model_edge(input bit rst, input bit vin, input logic [31:0] ai,
                              input logic [31:0] bi, input logic [3:0] op);
        u64_t res;
        bit   ov;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 0; m_r[d] = 0; m_zero[d] = 1; m_ovf[d] = 0; m_vout[d] = 0;
            end else if (m_busy[d] > 0) begin
                m_busy[d]--;
                m_vout[d] = (m_busy[d] == 0);
                if (m_busy[d] == 0) begin
                    m_r[d] = m_pend[d]; m_zero[d] = (m_pend[d] == 0); m_ovf[d] = m_pend_ovf[d];
                end
            end else if (vin) begin
                ref_op(c_w[d], op, u64_t'(ai), u64_t'(bi), res, ov);
                if (op == 4'd11) begin
                    m_busy[d] = c_w[d]; m_pend[d] = res; m_pend_ovf[d] = ov; m_vout[d] = 0;
                end else begin
                    m_r[d] = res; m_zero[d] = (res == 0); m_ovf[d] = ov; m_vout[d] = 1;
                end
            end else begin
                m_vout[d] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, check ready, clock, then check all outputs.
    task automatic step(input bit rst, input bit vin, input logic [31:0] ai,
                        input logic [31:0] bi, input logic [3:0] op);
        reset = rst; valid_in = vin; a = ai; b = bi; ctrl = op;
        check("ready32", rdy32, m_busy[0] == 0);
        check("ready8",  rdy8,  m_busy[1] == 0);
        @(posedge clk);
        #1;
        model_edge(rst, vin, ai, bi, op);
        check("R32",    r32, m_r[0]);
        check("zero32", z32, m_zero[0]);
        check("ovf32",  o32, m_ovf[0]);
        check("vout32", v32, m_vout[0]);
        check("R8",     r8,  m_r[1]);
        check("zero8",  z8,  m_zero[1]);
        check("ovf8",   o8,  m_ovf[1]);
        check("vout8",  v8,  m_vout[1]);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0080 | 32'($urandom_range(0, 127));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lowcnt;
        reset = 1'b1; valid_in = 1'b0; a = '0; b = '0; ctrl = '0;
        @(posedge clk);
        #1;
        model_edge(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        check("rst_R",      r32,   32'd0);
        check("rst_zero",   z32,   1'b1);
        check("rst_ovf",    o32,   1'b0);
        check("rst_vout",   v32,   1'b0);
        check("rst_ready",  rdy32, 1'b1);
        check("rst_ready8", rdy8,  1'b1);

        // Signed overflow on ADD
        step(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4'd0);
        check("add_R",    r32, 32'h8000_0000);
        check("add_ovf",  o32, 1'b1);
        check("add_zero", z32, 1'b0);
        check("add_vout", v32, 1'b1);

        // SUB to zero, then arithmetic right shift of a negative value
        step(1'b0, 1'b1, 32'd5, 32'd5, 4'd1);
        check("sub_R",    r32, 32'd0);
        check("sub_zero", z32, 1'b1);
        check("sub_ovf",  o32, 1'b0);
        step(1'b0, 1'b1, 32'h8000_0000, 32'd4, 4'd10);
        check("sra_R",    r32, 32'hF800_0000);
        check("sra_ovf",  o32, 1'b0);
        check("sra_vout", v32, 1'b1);

        // MUL with overflow; valid_in asserted during busy must be ignored
        step(1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000, 4'd11);
        check("mul_acc_vout", v32, 1'b0);
        lowcnt = 0;
        for (int i = 1; i <= 32; i++) begin
            if (rdy32 == 1'b0) lowcnt++;
            step(1'b0, 1'b1, $urandom, $urandom, 4'd0);
            check("mul_busy_vout", v32, (i == 32));
        end
        check("mul_ready_low", lowcnt, 32);
        check("mul_R",     r32,   32'd0);
        check("mul_zero",  z32,   1'b1);
        check("mul_ovf",   o32,   1'b1);
        check("mul_ready", rdy32, 1'b1);

        // MUL abandoned by reset at busy cycle 10 (reset beats valid_in)
        step(1'b0, 1'b1, 32'd3, 32'd7, 4'd11);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            check("mrst_busy_vout", v32, 1'b0);
        end
        step(1'b1, 1'b1, 32'd3, 32'd7, 4'd0);
        check("mrst_vout",  v32,   1'b0);
        check("mrst_R",     r32,   32'd0);
        check("mrst_zero",  z32,   1'b1);
        check("mrst_ready", rdy32, 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check("mrst_after_vout", v32, 1'b0);

        // Reserved opcode
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd13);
        check("rsv_R",    r32, 32'd0);
        check("rsv_zero", z32, 1'b1);
        check("rsv_ovf",  o32, 1'b0);
        check("rsv_vout", v32, 1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 6000; n++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
                 pick(), pick(), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
